// File: rtl/pwm_duty_decoder.sv
// PWM receiver: synchronises pwm_in, measures period and high time between rising edges,
// and derives the duty cycle in percent with a serial restoring divider.
module pwm_duty_decoder #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [6:0]       duty_pct,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             duty_valid,
    output logic             stuck,
    output logic             overrun
);

    localparam int NW = CNT_W + 7;
    localparam int IW = $clog2(NW);
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [IW-1:0]    LAST_IT = IW'(NW - 1);

    typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE} state_t;

    state_t           state;
    logic             sync1, sync2, sync_prev;
    logic             rise;
    logic [CNT_W-1:0] per_q, hi_q;
    logic [CNT_W-1:0] div_per, div_hi;
    logic [NW-1:0]    div_num;
    logic [CNT_W:0]   div_rem;
    logic [IW-1:0]    div_it;

    logic [CNT_W:0]   rem_sh, rem_nx;
    logic             q_bit;
    logic [NW-1:0]    quot;
    logic [6:0]       duty_clamped;
    logic [NW-1:0]    num_load;

    assign rise = sync2 & ~sync_prev;

    // One restoring-divide step; the quotient bits shift into the low end of div_num.
    always_comb begin
        rem_sh       = {div_rem[CNT_W-1:0], div_num[NW-1]};
        q_bit        = (rem_sh >= {1'b0, div_per});
        rem_nx       = q_bit ? (rem_sh - {1'b0, div_per}) : rem_sh;
        quot         = {div_num[NW-2:0], q_bit};
        duty_clamped = (quot > NW'(100)) ? 7'd100 : quot[6:0];
        num_load     = {7'b0, hi_q} * NW'(100);
    end

    // NOTE: every register here uses non-blocking assignment so all updates in a cycle
    // see the same pre-edge values; the divider registers are reset too so an aborted
    // divide leaves nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync_prev  <= 1'b0;
            per_q      <= '0;
            hi_q       <= '0;
            div_per    <= '0;
            div_hi     <= '0;
            div_num    <= '0;
            div_rem    <= '0;
            div_it     <= '0;
            duty_pct   <= '0;
            period_cnt <= '0;
            high_cnt   <= '0;
            duty_valid <= 1'b0;
            stuck      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sync1      <= pwm_in;
            sync2      <= sync1;
            sync_prev  <= sync2;
            duty_valid <= 1'b0;

            // Counters include the edge cycle itself, so they restart at 1.
            if (rise) begin
                per_q <= CNT_W'(1);
                hi_q  <= CNT_W'(1);
            end else begin
                if (per_q != '1)
                    per_q <= per_q + CNT_W'(1);
                hi_q <= hi_q + CNT_W'(sync2);
            end

            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= MEASURE;
                    end else if (per_q == TO_VAL) begin
                        duty_pct   <= sync2 ? 7'd100 : 7'd0;
                        period_cnt <= '0;
                        high_cnt   <= '0;
                        duty_valid <= 1'b1;
                        stuck      <= 1'b1;
                        per_q      <= CNT_W'(1);
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        div_per <= per_q;
                        div_hi  <= hi_q;
                        div_num <= num_load;
                        div_rem <= '0;
                        div_it  <= '0;
                        state   <= DIVIDE;
                    end else if (per_q == TO_VAL) begin
                        duty_pct   <= sync2 ? 7'd100 : 7'd0;
                        period_cnt <= '0;
                        high_cnt   <= '0;
                        duty_valid <= 1'b1;
                        stuck      <= 1'b1;
                        per_q      <= CNT_W'(1);
                        state      <= IDLE;
                    end
                end
                DIVIDE: begin
                    // An edge here loses its period; the counters above still restart.
                    if (rise)
                        overrun <= 1'b1;
                    div_rem <= rem_nx;
                    div_num <= quot;
                    div_it  <= div_it + IW'(1);
                    if (div_it == LAST_IT) begin
                        duty_pct   <= duty_clamped;
                        period_cnt <= div_per;
                        high_cnt   <= div_hi;
                        duty_valid <= 1'b1;
                        stuck      <= 1'b0;
                        state      <= MEASURE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
